// File: rtl/inters_seq_gen_pkg.sv
// Shared types and constants for the intersect-style frame stimulus generator.
// Contents: FSM state enum, error-injection mode enum, the frame output bundle,
// and a helper that maps a state onto the frame signals it drives.
package inters_pkg;

   localparam int unsigned DIV_MAX = 16;
   localparam int unsigned TICK_W  = $clog2(DIV_MAX);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEAD   = 3'd1,
      WAIT_C = 3'd2,
      TAIL   = 3'd3,
      GAP    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      MODE_LEGAL  = 2'd0,
      MODE_DROP_B = 2'd1,
      MODE_DROP_D = 2'd2,
      MODE_DROP_C = 2'd3
   } mode_t;

   typedef struct packed {
      logic e;
      logic a;
      logic b;
      logic c;
      logic d;
      logic f;
   } frame_t;

   // Frame signals for the cycle spent in state st; tick is that cycle's strobe.
   function automatic frame_t frame_for(state_t st, logic tick, mode_t m);
      frame_t fr;
      fr = '0;
      case (st)
         HEAD: begin
            fr.e = 1'b1;
            fr.a = 1'b1;
         end
         WAIT_C: fr.c = tick && (m != MODE_DROP_C);
         TAIL: begin
            fr.b = (m != MODE_DROP_B);
            fr.d = (m != MODE_DROP_D);
            fr.f = (m != MODE_LEGAL);
         end
         default: fr = '0;
      endcase
      return fr;
   endfunction

endpackage

// File: rtl/inters_seq_gen_if.sv
// Control and frame signal group of the stimulus generator.
// master: the generator (takes start/mode/gap/num_txn, drives status and frame).
// slave : the requester / monitor side.
interface inters_seq_gen_if
   import inters_pkg::*;
#(
   parameter int unsigned GAP_W = 4,
   parameter int unsigned CNT_W = 16
);

   logic             start;
   mode_t            mode;
   logic [GAP_W-1:0] gap;
   logic [CNT_W-1:0] num_txn;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] txn_cnt;
   logic             clk2_tick;
   logic             e;
   logic             a;
   logic             b;
   logic             c;
   logic             d;
   logic             f;

   modport master (
      input  start, mode, gap, num_txn,
      output busy, done, txn_cnt, clk2_tick, e, a, b, c, d, f
   );

   modport slave (
      output start, mode, gap, num_txn,
      input  busy, done, txn_cnt, clk2_tick, e, a, b, c, d, f
   );

endinterface

// File: rtl/inters_seq_gen_tick_div.sv
// Free-running modulo-DIV counter producing the slow-domain strobe.
// Ports: clk, rst (async, active-high);
//        tick       - registered strobe, high when the count is DIV-1;
//        tick_nxt_c - combinational value tick takes after the next edge.
module inters_tick_div
   import inters_pkg::*;
#(
   parameter int unsigned DIV = 3
) (
   input  logic clk,
   input  logic rst,
   output logic tick,
   output logic tick_nxt_c
);

   localparam logic [TICK_W-1:0] LAST = TICK_W'(DIV - 1);

   logic [TICK_W-1:0] cnt_q;
   logic [TICK_W-1:0] cnt_nxt;

   // Next count and look-ahead strobe (lets the FSM register c in the tick cycle).
   always_comb begin
      cnt_nxt    = (cnt_q == LAST) ? '0 : cnt_q + TICK_W'(1);
      tick_nxt_c = (cnt_nxt == LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         tick  <= tick_nxt_c;
      end
   end

endmodule

// File: rtl/inters_seq_gen.sv
// Registered frame stimulus generator for the intersect-style checkers.
// Drives bursts of e/a -> c (on a slow tick) -> b/d frames with optional
// single-signal drops flagged on f.
// Ports: clk, rst (async, active-high);
//        bus (master): start/mode/gap/num_txn in; busy/done/txn_cnt/clk2_tick
//                      and frame signals e/a/b/c/d/f out, all registered.
module inters_seq_gen
   import inters_pkg::*;
#(
   parameter int unsigned DIV   = 3,
   parameter int unsigned GAP_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   inters_seq_gen_if.master      bus
);

   localparam logic [CNT_W-1:0] TXN_MAX = {CNT_W{1'b1}};

   logic             tick;
   logic             tick_nxt_c;

   state_t           state_q, state_d;
   mode_t            mode_q, mode_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] txn_q, txn_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   frame_t           frm_q, frm_d;

   inters_tick_div #(.DIV(DIV)) u_tick (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .tick_nxt_c (tick_nxt_c)
   );

   // Next-state, burst bookkeeping and next-cycle outputs.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      rem_d   = rem_q;
      txn_d   = txn_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               txn_d = '0;
               if (bus.num_txn != '0) begin
                  mode_d  = bus.mode;
                  gap_d   = bus.gap;
                  rem_d   = bus.num_txn;
                  state_d = HEAD;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         HEAD: state_d = WAIT_C;
         // tick is this cycle's strobe: c was already driven, move on.
         WAIT_C: begin
            if (tick) state_d = TAIL;
         end
         TAIL: begin
            txn_d = (txn_q == TXN_MAX) ? txn_q : txn_q + CNT_W'(1);
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (gap_q == '0) begin
               state_d = HEAD;
            end else begin
               gcnt_d  = gap_q - GAP_W'(1);
               state_d = GAP;
            end
         end
         GAP: begin
            if (gcnt_q == '0) state_d = HEAD;
            else              gcnt_d  = gcnt_q - GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      frm_d  = frame_for(state_d, tick_nxt_c, mode_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_LEGAL;
         gap_q   <= '0;
         gcnt_q  <= '0;
         rem_q   <= '0;
         txn_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         frm_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         rem_q   <= rem_d;
         txn_q   <= txn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         frm_q   <= frm_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.txn_cnt   = txn_q;
   assign bus.clk2_tick = tick;
   assign bus.e         = frm_q.e;
   assign bus.a         = frm_q.a;
   assign bus.b         = frm_q.b;
   assign bus.c         = frm_q.c;
   assign bus.d         = frm_q.d;
   assign bus.f         = frm_q.f;

endmodule

// File: tb/tb_inters_seq_gen.sv
// Bench for inters_seq_gen: timeline model of expected outputs per cycle,
// directed scenarios with literal pins, then randomized bursts.
module tb_inters_seq_gen;
   import inters_pkg::*;

   localparam int unsigned DIV   = 3;
   localparam int unsigned GAP_W = 4;
   localparam int unsigned CNT_W = 16;
   localparam int          DIVI  = 3;
   localparam int          N     = 16384;

   logic clk = 1'b0;
   logic rst = 1'b1;

   inters_seq_gen_if #(.GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();

   inters_seq_gen #(.DIV(DIV), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected timeline, indexed by cycles since the last reset release.
   bit ex_head [N];
   bit ex_c    [N];
   bit ex_b    [N];
   bit ex_d    [N];
   bit ex_f    [N];
   bit ex_busy [N];
   bit ex_done [N];
   int ex_txn  [N];

   int cyc;
   int busy_end;
   int model_txn;
   int n_chk;
   int n_fail;
   bit checking;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         ex_head[i] = 0; ex_c[i] = 0; ex_b[i] = 0; ex_d[i] = 0;
         ex_f[i] = 0; ex_busy[i] = 0; ex_done[i] = 0; ex_txn[i] = -1;
      end
      busy_end  = -1;
      model_txn = 0;
   endtask

   // Lay out the frames a start in cycle s must produce.
   task automatic model_start(input int s, input int m, input int g, input int n);
      int t, tc, tail;
      if (s <= busy_end) return;
      if (n == 0) begin
         ex_done[s+1] = 1;
         ex_txn[s+1]  = 0;
         return;
      end
      ex_txn[s+1] = 0;
      t    = s + 1;
      tail = t;
      for (int i = 0; i < n; i++) begin
         ex_head[t] = 1;
         tc = t + 1;
         while (tc % DIVI != DIVI - 1) tc++;
         ex_c[tc]   = (m != 3);
         tail       = tc + 1;
         ex_b[tail] = (m != 1);
         ex_d[tail] = (m != 2);
         ex_f[tail] = (m != 0);
         ex_txn[tail+1] = i + 1;
         t = tail + 1 + g;
      end
      for (int k = s + 1; k <= tail; k++) ex_busy[k] = 1;
      ex_done[tail+1] = 1;
      busy_end = tail;
   endtask

   always @(posedge clk) if (!rst) cyc = cyc + 1;

   // Per-cycle comparison of every output against the timeline.
   always @(negedge clk) begin
      if (checking && !rst && cyc < N) begin
         logic [24:0] act, exp;
         bit tk;
         if (ex_txn[cyc] >= 0) model_txn = ex_txn[cyc];
         tk  = (cyc % DIVI) == (DIVI - 1);
         act = {bus.busy, bus.done, bus.clk2_tick, bus.e, bus.a, bus.b, bus.c,
                bus.d, bus.f, bus.txn_cnt};
         exp = {ex_busy[cyc], ex_done[cyc], tk, ex_head[cyc], ex_head[cyc],
                ex_b[cyc], ex_c[cyc], ex_d[cyc], ex_f[cyc], CNT_W'(model_txn)};
         check($sformatf("cycle %0d outputs", cyc), 64'(act), 64'(exp));
      end
   end

   // Advance to #1 after the edge that starts cycle k.
   task automatic goto(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input int m, input int g, input int n);
      bus.start   = 1'b1;
      bus.mode    = mode_t'(2'(m));
      bus.gap     = GAP_W'(g);
      bus.num_txn = CNT_W'(n);
      model_start(cyc, m, g, n);
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      bus.mode    = mode_t'(2'($urandom_range(3)));
      bus.gap     = GAP_W'($urandom_range(15));
      bus.num_txn = CNT_W'($urandom_range(9));
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      model_clear();
      cyc = 0;
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; checking = 0;
      bus.start = 1'b0; bus.mode = MODE_LEGAL; bus.gap = '0; bus.num_txn = '0;
      model_clear();
      #2;
      check("reset_outputs", 64'({bus.busy, bus.done, bus.clk2_tick, bus.e, bus.a,
            bus.b, bus.c, bus.d, bus.f, bus.txn_cnt}), 64'd0);
      release_reset();
      checking = 1;

      // Tick phase after reset.
      goto(2); check("tick_c2", 64'(bus.clk2_tick), 64'd1);
      goto(3); check("tick_c3", 64'(bus.clk2_tick), 64'd0);

      // Single legal frame, HEAD on tick cycle 5.
      goto(4); issue(0, 0, 1);
      check("model_head5", 64'(ex_head[5]), 64'd1);
      check("model_c8", 64'(ex_c[8]), 64'd1);
      check("model_done10", 64'(ex_done[10]), 64'd1);
      check("h5_ea", 64'({bus.e, bus.a, bus.clk2_tick}), 64'b111);
      goto(8); check("c8", 64'({bus.c, bus.clk2_tick}), 64'b11);
      goto(9); check("tail9_bdf", 64'({bus.b, bus.d, bus.f}), 64'b110);
      goto(10); check("done10", 64'({bus.done, bus.busy, bus.txn_cnt}), 64'({1'b1, 1'b0, 16'd1}));

      // Three frames with gap 2.
      goto(12); issue(0, 2, 3);
      goto(17); check("gap17", 64'({bus.busy, bus.e}), 64'b10);
      goto(18); check("head18", 64'(bus.e), 64'd1);
      goto(24); check("head24", 64'(bus.e), 64'd1);
      goto(28); check("done28", 64'({bus.done, bus.txn_cnt}), 64'({1'b1, 16'd3}));
      goto(29); check("after29", 64'({bus.busy, bus.done, bus.e}), 64'd0);

      // Error injection modes.
      goto(30); issue(1, 0, 1);
      goto(33); check("drop_b33", 64'({bus.b, bus.d, bus.f}), 64'b011);
      goto(35); issue(2, 0, 1);
      goto(39); check("drop_d39", 64'({bus.b, bus.d, bus.f}), 64'b101);
      goto(41); issue(3, 0, 1);
      goto(44); check("drop_c44", 64'({bus.c, bus.clk2_tick}), 64'b01);
      goto(45); check("tail45", 64'({bus.b, bus.d, bus.f}), 64'b111);

      // Zero-length burst and an ignored start mid-burst.
      goto(48); issue(0, 3, 0);
      check("zero49", 64'({bus.done, bus.busy, bus.e, bus.txn_cnt}), 64'({1'b1, 1'b0, 1'b0, 16'd0}));
      goto(52); issue(0, 1, 2);
      goto(55); issue(1, 0, 5);
      goto(64); check("done64", 64'({bus.done, bus.txn_cnt, bus.f}), 64'({1'b1, 16'd2, 1'b0}));

      // Reset while waiting for c.
      goto(70); issue(0, 0, 3);
      goto(72);
      rst = 1'b1;
      #1;
      check("async_reset", 64'({bus.busy, bus.done, bus.clk2_tick, bus.e, bus.a,
            bus.b, bus.c, bus.d, bus.f, bus.txn_cnt}), 64'd0);
      release_reset();
      goto(2); issue(0, 1, 2);

      // Randomized bursts, frequently overlapping a busy generator.
      for (int it = 0; it < 40; it++) begin
         goto(cyc + int'($urandom_range(25)));
         if (cyc < N - 400)
            issue(int'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(5)));
      end

      goto(((busy_end > cyc) ? busy_end : cyc) + 4);
      checking = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/inters_seq_gen.md
Name: inters_seq_gen

Overview:
- Registered stimulus generator that drives frames on the a/b/c/d/e/f signal group for the intersect-style property checkers.
- It is the driving end of the frame protocol those checkers monitor. It produces legal frames, or frames with deliberate defects (error injection).
- It also produces a slow-domain sample strobe, clk2_tick, that stands in for the second clock.

Parameters:
- DIV, 3, clk2_tick period in clk cycles; legal range 2..16.
- GAP_W, 4, width of the inter-frame gap field.
- CNT_W, 16, width of the frame count and the completed-frame counter.

Ports:
- clk  input  1  the single clock; all logic is on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to start a burst; ignored while busy=1.
- mode  input  2  0 = legal, 1 = drop b, 2 = drop d, 3 = drop c; sampled when start is accepted.
- gap  input  GAP_W  number of idle cycles between frames; sampled when start is accepted.
- num_txn  input  CNT_W  number of frames in the burst; sampled when start is accepted.
- busy  output  1  high from the cycle after start is accepted until the frame sequence ends.
- done  output  1  one-cycle pulse when the burst completes.
- txn_cnt  output  CNT_W  number of frames completed in the current or most recent burst.
- clk2_tick  output  1  slow-domain strobe; high for 1 cycle in every DIV cycles.
- e, a, b, c, d  output  1 each  frame signals.
- f  output  1  injected-error marker.

Behaviour:
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- Tick counter:
  - Free-running modulo DIV, starting at 0 after reset.
  - clk2_tick=1 when the count equals DIV-1.
  - It runs in every state and is unaffected by start.
- Frame definition, with T0 = HEAD cycle:
  - T0: e=1, a=1.
  - Tc: the first cycle at or after T0+1 with clk2_tick=1; c=1 in that cycle. A tick in the HEAD cycle does not count.
  - Tc+1 (TAIL): b=1, d=1.
  - Signals not listed for a cycle are 0.
- States:
  - IDLE: on start with num_txn≠0, capture mode, gap and num_txn; clear txn_cnt; go to HEAD. busy=1 from HEAD onward.
  - HEAD: drive e and a; go to WAIT_C.
  - WAIT_C: hold outputs low until the next tick cycle, then drive c=1 in that cycle and go to TAIL on the following edge. WAIT_C lasts 1..DIV cycles.
  - TAIL: drive b and d, and increment txn_cnt.
    - If this was the last frame: go to IDLE and assert done=1 in the next cycle; busy falls in that same cycle.
    - Otherwise, with gap=0: go directly to HEAD (back-to-back frames).
    - Otherwise: go to GAP.
  - GAP: exactly gap idle cycles, then HEAD. No gap follows the final frame.
- start with num_txn=0 in IDLE: no frame is generated. done=1 in the next cycle, txn_cnt clears to 0, and busy stays 0.
- Error injection, fixed for the whole burst:
  - mode 1: b=0 in TAIL.
  - mode 2: d=0 in TAIL.
  - mode 3: c=0 in the tick cycle. Timing is unchanged, so the generator still waits for the tick.
  - f=1 in the TAIL cycle of every frame whenever the captured mode≠0; otherwise f=0.
- txn_cnt saturates at its maximum value. It holds after done until the next accepted start clears it.
- start while busy=1 is ignored; mode, gap and num_txn changes while busy have no effect.
- Reset mid-frame: all outputs drop to 0 asynchronously and the burst is abandoned; no done pulse is produced.

Decomposition:
- Shared package inters_pkg holds:
  - the state enum (IDLE, HEAD, WAIT_C, TAIL, GAP);
  - the mode enum (MODE_LEGAL, MODE_DROP_B, MODE_DROP_D, MODE_DROP_C);
  - DIV_MAX = 16.
- One sub-module, inters_tick_div: the modulo-DIV counter producing clk2_tick, with the same clk/rst.

Test Plan:
- Reset release, DIV=3 → clk2_tick high at cycles 2, 5, 8 after reset; all frame outputs stay 0.
- start with mode=0, gap=0, num_txn=1, HEAD coinciding with tick cycle 5 → e=a=1 at 5, c=1 at 8, b=d=1 at 9, done=1 at 10, txn_cnt=1, f=0 throughout.
- mode=0, gap=2, num_txn=3 → three frames, each with exactly 2 idle cycles between TAIL and the next HEAD; txn_cnt steps 1, 2, 3; a single done pulse; no gap after frame 3.
- mode=1, 2 and 3, num_txn=1 each → respectively b, d or c is missing in the affected cycle, f=1 in TAIL, and frame timing is identical to the legal case.
- num_txn=0 start → done one cycle later, busy never rises, no e/a activity. A start pulse issued mid-burst → ignored, and frame count is unchanged.
- Assert rst during WAIT_C → all outputs 0 in the same cycle, state IDLE, no done pulse. A subsequent start runs normally.
